if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  - Parametrised fetch-to-decode pipeline register. Generalises the single IF/ID latch into a
//    DEPTH-entry instruction/PC queue with valid/ready handshakes, branch flush and NOP bubbles.
//  - Sits between the fetch unit (PC + instruction memory) and decode. It absorbs decode stalls
//    without losing fetched words. A taken branch empties it cleanly.
// PARAMETERS
//  - INS_W      32            instruction width (bits)
//  - PC_W       32            program-counter width (bits)
//  - DEPTH      2             queue entries; power of two, >= 2
//  - NOP_INSTR  32'h00000000  encoding driven on ins_out while the queue is empty (INS_W bits)
// PORTS
//  - clk        in   1                 rising-edge clock
//  - rst_n      in   1                 asynchronous active-low reset
//  - flush      in   1                 synchronous flush (branch taken)
//  - in_valid   in   1                 fetch presents ins/pc_in
//  - in_ready   out  1                 queue can accept; equals !full
//  - ins        in   INS_W             fetched instruction
//  - pc_in      in   PC_W              PC of fetched instruction
//  - out_valid  out  1                 head entry valid for decode
//  - out_ready  in   1                 decode consumes head this cycle
//  - ins_out    out  INS_W             head instruction, or NOP_INSTR when empty
//  - pc_out     out  PC_W              head PC, or 0 when empty
//  - count      out  $clog2(DEPTH)+1   current occupancy
// BEHAVIOUR
//  - Reset (rst_n=0, async): rd/wr pointers=0, count=0, out_valid=0, in_ready=1, ins_out=NOP_INSTR,
//    pc_out=0. Storage contents are don't-care. Outputs hold these values until the first push.
//  - push = in_valid & in_ready. pop = out_valid & out_ready. Both are evaluated at the rising clk edge.
//  - in_ready = (count != DEPTH). It depends only on registered state; there is no combinational
//    path from out_ready to in_ready. When full, a push is refused even if a pop occurs in the same cycle.
//  - Latency: a word pushed at edge N appears on ins_out/pc_out with out_valid=1 after edge N
//    (1 cycle), provided older entries are already drained. FIFO order is strict.
//  - Outputs are driven from the head storage entry (first-word fall-through). When count==0:
//    out_valid=0, ins_out=NOP_INSTR, pc_out=0.
//  - Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
//  - Pointers wrap modulo DEPTH. count saturates logically at DEPTH via in_ready and never overflows.
//  - flush=1 at an edge has the highest priority: count=0, rd_ptr=wr_ptr=0, and any concurrent push
//    and pop are discarded. On the next cycle out_valid=0, ins_out=NOP_INSTR and in_ready=1.
//    Flush never drives X.
//  - Asserting rst_n low mid-operation clears the queue immediately (same state as flush, but
//    asynchronous). No entry survives reset.
//  - out_valid is never asserted with an X payload. ins/pc_in are sampled only on push.
// CONFIGURATION
//  - Macro IF_ID_QUEUE_PERF_EN.
//  - Defined: adds the outputs stall_cycles[15:0] and flush_count[7:0].
//    - stall_cycles increments each cycle in which in_valid & !in_ready.
//    - flush_count increments each cycle in which flush=1.
//    - Both saturate at all-ones, are cleared only by rst_n, and are unaffected by flush.
//  - Undefined: the counter ports and their logic are absent. Core behaviour is identical.
// TESTING
//  - Reset: hold rst_n=0 with random inputs -> out_valid=0, in_ready=1, count=0, ins_out=NOP_INSTR,
//    pc_out=0.
//  - Single push: push ins=32'h8C220004, pc=32'h00000010 with out_ready=0 -> next cycle out_valid=1,
//    ins_out=8C220004, pc_out=00000010, count=1.
//  - Fill/backpressure: DEPTH=2, push pcs 0x0, 0x4, then offer 0x8 with out_ready=0 -> in_ready=0,
//    0x8 not stored. Then pop twice -> outputs 0x0, then 0x4, in order.
//  - Streaming: in_valid=out_ready=1 for 10 cycles on pcs 0x0..0x24 -> every pc emitted once, in order,
//    count stays 1, no bubble after the first.
//  - Flush: queue holding 2 entries plus a concurrent push of pc=0x40 with flush=1 -> next cycle count=0,
//    out_valid=0, ins_out=NOP_INSTR, and 0x40 never appears.
//  - Perf (IF_ID_QUEUE_PERF_EN): keep full with in_valid=1 for 70000 cycles -> stall_cycles=16'hFFFF.
//    3 flushes -> flush_count=3.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode pipeline queue.
//
// DEPTH-entry FIFO of {instruction, PC} pairs between fetch and decode.
// Decode stalls are absorbed without losing fetched words. A taken branch
// (flush) empties the queue in one cycle. When the queue is empty, decode
// sees a NOP bubble.
//
// Optional feature: define IF_ID_QUEUE_PERF_EN to add two saturating
// performance counters, stall_cycles and flush_count. With the macro
// undefined, the counter ports and their logic are absent.
//
// Handshake contract (both sides use strict valid/ready):
//   - A transfer happens at a rising clk edge where valid & ready are both 1.
//   - in_ready is a function of registered occupancy only. There is no
//     combinational path from out_ready to in_ready.
//   - out_valid, ins_out and pc_out are driven from the head entry
//     (first-word fall-through). A push is visible one cycle after its edge.
//   - flush overrides both transfers in the same cycle.
//
// DEPTH must be a power of two and >= 2, so the pointers can wrap naturally.

module if_id_queue #(
    parameter int                 INS_W     = 32,
    parameter int                 PC_W      = 32,
    parameter int                 DEPTH     = 2,
    parameter logic [INS_W-1:0]   NOP_INSTR = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INS_W-1:0]         ins,
    input  logic [PC_W-1:0]          pc_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INS_W-1:0]         ins_out,
    output logic [PC_W-1:0]          pc_out,
    output logic [$clog2(DEPTH):0]   count
`ifdef IF_ID_QUEUE_PERF_EN
    ,
    output logic [15:0]              stall_cycles,
    output logic [7:0]               flush_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Pointer and occupancy state
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;

    // Payload storage. It is not reset: an entry is only ever read while
    // count_q says it holds a pushed word.
    logic [INS_W-1:0] ins_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem  [DEPTH];

    // Handshake decode
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Derive full/empty and the two transfer strobes from registered state
    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        push  = in_valid & ~full;
        pop   = out_ready & ~empty;
    end

    // Pointer and occupancy update; flush wins over any concurrent push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Write the fetched word into the tail slot on an accepted push
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            ins_mem[wr_ptr] <= ins;
            pc_mem[wr_ptr]  <= pc_in;
        end
    end

    // Present the head entry, or a NOP bubble with PC 0 when empty
    always_comb begin
        in_ready  = ~full;
        out_valid = ~empty;
        count     = count_q;
        ins_out   = NOP_INSTR;
        pc_out    = '0;
        if (!empty) begin
            ins_out = ins_mem[rd_ptr];
            pc_out  = pc_mem[rd_ptr];
        end
    end

`ifdef IF_ID_QUEUE_PERF_EN
    // Saturating counters; only rst_n clears them, flush leaves them alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (in_valid && full && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (flush && (flush_count != 8'hFF)) begin
                flush_count <= flush_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Testbench for if_id_queue (DEPTH=2). It uses directed vectors and a
// scoreboard queue of expected {ins, pc} words. A monitor pops and compares
// that queue on every decode handshake.

module tb_if_id_queue;

    localparam int   DEPTH = 2;
    localparam int   CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   ins;
    logic [31:0]   pc_in;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   ins_out;
    logic [31:0]   pc_out;
    logic [CW-1:0] count;
`ifdef IF_ID_QUEUE_PERF_EN
    logic [15:0]   stall_cycles;
    logic [7:0]    flush_count;
`endif

    always #5 clk = ~clk;

    if_id_queue #(
        .INS_W    (32),
        .PC_W     (32),
        .DEPTH    (DEPTH),
        .NOP_INSTR(NOP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ins      (ins),
        .pc_in    (pc_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ins_out  (ins_out),
        .pc_out   (pc_out),
        .count    (count)
`ifdef IF_ID_QUEUE_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];   // {ins, pc} in expected decode order
    int          mcount;     // expected occupancy
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        mon_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drives one cycle of inputs (called at posedge+1), then advances the
    // expected model at the edge.
    task automatic cyc(input logic iv, input logic [31:0] i, input logic [31:0] p,
                       input logic ordy, input logic fl);
        logic pu;
        logic po;
        in_valid  = iv;
        ins       = i;
        pc_in     = p;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        if (fl) begin
            mcount = 0;
            exp_q.delete();
        end else begin
            pu = iv && (mcount != DEPTH);
            po = ordy && (mcount != 0);
            if (pu) exp_q.push_back({i, p});
            mcount = mcount + int'(pu) - int'(po);
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        ins       = '0;
        pc_in     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        idle_inputs();
        rst_n = 1'b0;
        mcount = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    // ---------------- monitor ----------------
    // Samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("count", 64'(count), 64'(mcount));
            chk("out_valid", 64'(out_valid), 64'(mcount != 0));
            chk("in_ready", 64'(in_ready), 64'(mcount != DEPTH));
            if (mcount == 0) begin
                chk("empty_ins_out", 64'(ins_out), 64'(NOP));
                chk("empty_pc_out", 64'(pc_out), 64'h0);
            end
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", {ins_out, pc_out}, 64'h0);
                end else begin
                    chk("pop_word", {ins_out, pc_out}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: time limit reached before end of test");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        mcount = 0;
        idle_inputs();
        rst_n = 1'b0;

        // Reset held with random inputs
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = 1'($urandom_range(0, 1));
            ins       = $urandom;
            pc_in     = $urandom;
            #1;
            chk("rst_out_valid", 64'(out_valid), 64'h0);
            chk("rst_in_ready", 64'(in_ready), 64'h1);
            chk("rst_count", 64'(count), 64'h0);
            chk("rst_ins_out", 64'(ins_out), 64'(NOP));
            chk("rst_pc_out", 64'(pc_out), 64'h0);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Single push with decode stalled
        cyc(1'b1, 32'h8C22_0004, 32'h0000_0010, 1'b0, 1'b0);
        chk("single_valid", 64'(out_valid), 64'h1);
        chk("single_ins", 64'(ins_out), 64'h8C22_0004);
        chk("single_pc", 64'(pc_out), 64'h10);
        chk("single_count", 64'(count), 64'h1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Fill and backpressure: 0x8 refused, including with a same-cycle pop
        cyc(1'b1, 32'hA000_0000, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'hA000_0004, 32'h4, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'h0);
        chk("full_count", 64'(count), 64'h2);
        cyc(1'b1, 32'hA000_0008, 32'h8, 1'b0, 1'b0);
        chk("refused_count", 64'(count), 64'h2);
        cyc(1'b1, 32'hA000_0008, 32'h8, 1'b1, 1'b0);
        chk("full_pushpop_count", 64'(count), 64'h1);
        chk("second_head_pc", 64'(pc_out), 64'h4);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drained_count", 64'(count), 64'h0);

        // Streaming: pcs 0x0..0x24, count stays at 1
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 32'hB000_0000 | 32'(k * 4), 32'(k * 4), 1'b1, 1'b0);
            chk("stream_count", 64'(count), 64'h1);
            chk("stream_head_pc", 64'(pc_out), 64'(k * 4));
        end
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush with two entries held and a concurrent push of 0x40
        cyc(1'b1, 32'hC000_0030, 32'h30, 1'b0, 1'b0);
        cyc(1'b1, 32'hC000_0034, 32'h34, 1'b0, 1'b0);
        cyc(1'b1, 32'hC000_0040, 32'h40, 1'b1, 1'b1);
        chk("flush_count0", 64'(count), 64'h0);
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        chk("flush_ins_out", 64'(ins_out), 64'(NOP));
        chk("flush_in_ready", 64'(in_ready), 64'h1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1'b1, 32'hC000_0050, 32'h50, 1'b0, 1'b0);
        chk("post_flush_pc", 64'(pc_out), 64'h50);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-operation
        cyc(1'b1, 32'hD000_0060, 32'h60, 1'b0, 1'b0);
        cyc(1'b1, 32'hD000_0064, 32'h64, 1'b0, 1'b0);
        mon_en = 1'b0;
        idle_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'h0);
        chk("async_rst_valid", 64'(out_valid), 64'h0);
        chk("async_rst_pc", 64'(pc_out), 64'h0);
        mcount = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc(1'b1, 32'hD000_0070, 32'h70, 1'b0, 1'b0);
        chk("after_rst_pc", 64'(pc_out), 64'h70);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

`ifdef IF_ID_QUEUE_PERF_EN
        // Perf counters: saturate stall_cycles, then 3 flushes
        do_reset();
        cyc(1'b1, 32'hE000_0000, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'hE000_0004, 32'h4, 1'b0, 1'b0);
        chk("perf_stall_start", 64'(stall_cycles), 64'h0);
        for (int k = 0; k < 70000; k++) begin
            cyc(1'b1, 32'hE000_0008, 32'h8, 1'b0, 1'b0);
        end
        chk("perf_stall_sat", 64'(stall_cycles), 64'hFFFF);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b1);
        end
        chk("perf_flush_count", 64'(flush_count), 64'h3);
        chk("perf_stall_kept", 64'(stall_cycles), 64'hFFFF);
`endif

        // Nothing should be left outstanding
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
